// File: rtl/sk_wide_add_seq.sv
// Multi-cycle wide adder/subtractor. One 64-bit limb pair per cycle goes
// through a single Sklansky prefix adder, LSB limb first, with a registered carry chain.

module SKadder_64 (
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  input  logic        cin_i,
  output logic [63:0] sum_o,
  output logic        cout_o
);

  logic [63:0] gen, prop, grpG, grpP, nxtG, nxtP;
  int          j;

  // Sklansky prefix tree. Carry-in is folded into bit 0's generate, so
  // grpG[i] is the carry out of bit i.
  always_comb begin
    gen  = a_i & b_i;
    prop = a_i ^ b_i;
    grpG = gen;
    grpP = prop;
    grpG[0] = gen[0] | (prop[0] & cin_i);
    nxtG = grpG;
    nxtP = grpP;
    j    = 0;
    for (int l = 0; l < 6; l++) begin
      nxtG = grpG;
      nxtP = grpP;
      for (int i = 0; i < 64; i++) begin
        if (((i >> l) & 1) == 1) begin
          j       = ((i >> l) << l) - 1;
          nxtG[i] = grpG[i] | (grpP[i] & grpG[j]);
          nxtP[i] = grpP[i] & grpP[j];
        end
      end
      grpG = nxtG;
      grpP = nxtP;
    end
    sum_o  = prop ^ {grpG[62:0], cin_i};
    cout_o = grpG[63];
  end

endmodule

module sk_wide_add_seq #(
  parameter int LIMBS = 4,
  localparam int W    = 64 * LIMBS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  input  logic         in_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout,
  output logic         out_ovf,
  output logic         busy
);

  localparam int LW = (LIMBS > 1) ? $clog2(LIMBS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   limb_q, limb_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic            valid_q, valid_d;

  logic [63:0]     addA, addB, addSum;
  logic            addCout;
  logic            lastLimb;
  logic            accept;

  SKadder_64 u_adder (
    .a_i    (addA),
    .b_i    (addB),
    .cin_i  (carry_q),
    .sum_o  (addSum),
    .cout_o (addCout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      limb_q  <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      limb_q  <= limb_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (lastLimb) state_d = DONE;
      DONE:    if (valid_q && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1, so B is inverted and the carry forced at accept.
  always_comb begin
    in_ready  = ~rst && (state_q == IDLE);
    busy      = (state_q == RUN) || (state_q == DONE);
    accept    = in_valid && in_ready;
    lastLimb  = (limb_q == LW'(LIMBS - 1));
    addA      = a_q[{limb_q, 6'b0} +: 64];
    addB      = b_q[{limb_q, 6'b0} +: 64];
    out_valid = valid_q;
    out_sum   = sum_q;
    out_cout  = cout_q;
    out_ovf   = ovf_q;

    limb_d  = limb_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = in_a;
          b_d     = in_sub ? ~in_b : in_b;
          carry_d = in_sub | in_cin;
          limb_d  = '0;
        end
      end
      RUN: begin
        sum_d[{limb_q, 6'b0} +: 64] = addSum;
        carry_d = addCout;
        limb_d  = limb_q + LW'(1);
        if (lastLimb) begin
          limb_d  = '0;
          cout_d  = addCout;
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (addSum[63] != a_q[W-1]);
          valid_d = 1'b1;
        end
      end
      DONE: begin
        if (valid_q && out_ready) valid_d = 1'b0;
      end
      default: ;
    endcase
  end

endmodule
